// File: rtl/alarm_count_ctrl.sv
// Two-digit BCD up/down alarm counter with tick prescaler, preset load, threshold compare and buzzer pattern.
// Registered digits/sp/alarm_flag/state; tick and running decode combinationally from state and prescaler.
module alarm_count_ctrl #(
  parameter int TICK_DIV    = 2500000,
  parameter int BEEP_TICKS  = 4,
  parameter int ALARM_BEEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] alarm_val,
  input  logic       ack,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic       tick,
  output logic       running,
  output logic       sp,
  output logic       alarm_flag,
  output logic [1:0] state_o
);

  localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BT_W = $clog2(BEEP_TICKS + 1);
  localparam int BC_W = $clog2(ALARM_BEEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [3:0]      r_ten, r_one, w_ten_nxt, w_one_nxt;
  logic [BT_W-1:0] r_bt, w_bt_nxt;
  logic [BC_W-1:0] r_bc, w_bc_nxt;
  logic            r_sp, w_sp_nxt;
  logic            r_flag, w_flag_nxt;

  logic            w_pc_last;
  logic            w_load_ok;
  logic [3:0]      w_cnt_ten, w_cnt_one;
  logic            w_hit;

  assign w_pc_last = (r_pc == PC_W'(TICK_DIV - 1));
  assign w_load_ok = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

  always_comb begin
    w_cnt_ten = r_ten;
    w_cnt_one = r_one;
    if (!dir) begin
      if (r_one == 4'd9) begin
        w_cnt_one = 4'd0;
        w_cnt_ten = (r_ten == 4'd9) ? 4'd0 : r_ten + 4'd1;
      end else begin
        w_cnt_one = r_one + 4'd1;
      end
    end else begin
      if (r_one == 4'd0) begin
        w_cnt_one = 4'd9;
        w_cnt_ten = (r_ten == 4'd0) ? 4'd9 : r_ten - 4'd1;
      end else begin
        w_cnt_one = r_one - 4'd1;
      end
    end
  end

  // Updated count is always valid BCD, so an out-of-range alarm digit can never match.
  assign w_hit = ({w_cnt_ten, w_cnt_one} == alarm_val);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ten_nxt   = r_ten;
    w_one_nxt   = r_one;
    w_bt_nxt    = r_bt;
    w_bc_nxt    = r_bc;
    w_sp_nxt    = r_sp;
    w_flag_nxt  = r_flag;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt = '0;
        if (ack) begin
          w_flag_nxt = 1'b0;
        end else if (!stop && start) begin
          w_state_nxt = S_RUN;
          w_flag_nxt  = 1'b0;
        end else if (!stop && w_load_ok) begin
          w_ten_nxt = load_val[7:4];
          w_one_nxt = load_val[3:0];
        end
      end
      S_RUN: begin
        if (!stop) begin
          if (w_pc_last) begin
            w_pc_nxt  = '0;
            w_ten_nxt = w_cnt_ten;
            w_one_nxt = w_cnt_one;
            if (w_hit) begin
              w_state_nxt = S_ALARM;
              w_sp_nxt    = 1'b1;
              w_flag_nxt  = 1'b1;
              w_bt_nxt    = '0;
              w_bc_nxt    = '0;
            end
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
          w_flag_nxt  = 1'b0;
        end else if (!stop && start) begin
          w_state_nxt = S_RUN;
        end else if (!stop && w_load_ok) begin
          w_ten_nxt = load_val[7:4];
          w_one_nxt = load_val[3:0];
        end
      end
      S_ALARM: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
          w_sp_nxt    = 1'b0;
          w_flag_nxt  = 1'b0;
          w_bt_nxt    = '0;
          w_bc_nxt    = '0;
        end else if (w_pc_last) begin
          w_pc_nxt = '0;
          if (r_bt == BT_W'(BEEP_TICKS - 1)) begin
            w_bt_nxt = '0;
            if (r_sp) begin
              w_sp_nxt = 1'b0;
              w_bc_nxt = r_bc + BC_W'(1);
            end else if (r_bc == BC_W'(ALARM_BEEPS)) begin
              // Exit after the last beep's off-phase so every beep gets a full on/off period.
              w_state_nxt = S_IDLE;
              w_bc_nxt    = '0;
            end else begin
              w_sp_nxt = 1'b1;
            end
          end else begin
            w_bt_nxt = r_bt + BT_W'(1);
          end
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ten   <= 4'd0;
      r_one   <= 4'd0;
      r_bt    <= '0;
      r_bc    <= '0;
      r_sp    <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ten   <= w_ten_nxt;
      r_one   <= w_one_nxt;
      r_bt    <= w_bt_nxt;
      r_bc    <= w_bc_nxt;
      r_sp    <= w_sp_nxt;
      r_flag  <= w_flag_nxt;
    end
  end

  // A stop on the tick cycle suppresses the tick so the count never moves on a pausing edge.
  assign tick       = (r_state == S_RUN) && w_pc_last && !stop;
  assign running    = (r_state == S_RUN);
  assign ten        = r_ten;
  assign one        = r_one;
  assign sp         = r_sp;
  assign alarm_flag = r_flag;
  assign state_o    = r_state;

endmodule

// File: tb/tb_alarm_count_ctrl.sv
// Randomised and directed stimulus against a cycle-level behavioural model; a negedge monitor
// pops expected outputs from a scoreboard queue and compares them with the DUT.
module tb_alarm_count_ctrl;

  localparam int TD = 4;
  localparam int BT = 2;
  localparam int AB = 3;
  localparam int ALARM_LEN = 2 * AB * BT * TD;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir, load, ack;
  logic [7:0] load_val, alarm_val;
  logic [3:0] ten, one;
  logic       tick, running, sp, alarm_flag;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  alarm_count_ctrl #(.TICK_DIV(TD), .BEEP_TICKS(BT), .ALARM_BEEPS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .alarm_val(alarm_val), .ack(ack),
    .ten(ten), .one(one), .tick(tick), .running(running), .sp(sp),
    .alarm_flag(alarm_flag), .state_o(state_o)
  );

  typedef struct packed {
    logic       tick;
    logic       running;
    logic [3:0] ten;
    logic [3:0] one;
    logic       sp;
    logic       flag;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Model: state 0..3, count as integer 0..99, prescaler, cycles spent in alarm.
  int m_st = 0, m_cnt = 0, m_pc = 0, m_acyc = 0;
  bit m_flag = 1'b0;

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int bcd_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_st = 0; m_cnt = 0; m_pc = 0; m_acyc = 0; m_flag = 1'b0;
      return;
    end
    case (m_st)
      0: begin
        if (ack) m_flag = 1'b0;
        else if (!stop && start) begin m_st = 1; m_pc = 0; m_flag = 1'b0; end
        else if (!stop && load && bcd_ok(load_val)) m_cnt = bcd_val(load_val);
      end
      1: begin
        if (stop) m_st = 2;
        else if (m_pc == TD - 1) begin
          m_pc  = 0;
          m_cnt = dir ? (m_cnt + 99) % 100 : (m_cnt + 1) % 100;
          if (bcd_ok(alarm_val) && m_cnt == bcd_val(alarm_val)) begin
            m_st = 3; m_acyc = 0; m_flag = 1'b1;
          end
        end else m_pc = m_pc + 1;
      end
      2: begin
        if (ack) begin m_st = 0; m_pc = 0; m_flag = 1'b0; end
        else if (!stop && start) m_st = 1;
        else if (!stop && load && bcd_ok(load_val)) m_cnt = bcd_val(load_val);
      end
      default: begin
        if (ack) begin m_st = 0; m_pc = 0; m_flag = 1'b0; end
        else if (m_acyc + 1 == ALARM_LEN) begin m_st = 0; m_pc = 0; end
        else m_acyc = m_acyc + 1;
      end
    endcase
  endfunction

  task automatic cycle();
    exp_t e;
    e.tick    = (m_st == 1) && (m_pc == TD - 1) && !stop;
    e.running = (m_st == 1);
    e.ten     = 4'(m_cnt / 10);
    e.one     = 4'(m_cnt % 10);
    e.sp      = (m_st == 3) && (((m_acyc / (BT * TD)) % 2) == 0);
    e.flag    = m_flag;
    e.st      = 2'(m_st);
    q.push_back(e);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; ack = 1'b0;
  endtask

  task automatic run_until_state(input int s);
    int guard = 0;
    while (m_st != s && guard < 300) begin cycle(); guard++; end
    n_vec++;
    if (m_st != s) begin
      n_bad++;
      $display("FAIL wait_state: model state %0d, required %0d within 300 cycles", m_st, s);
    end
  endtask

  task automatic run_until_tick();
    int guard = 0;
    while (!(m_st == 1 && m_pc == TD - 1) && guard < 100) begin cycle(); guard++; end
    n_vec++;
    if (!(m_st == 1 && m_pc == TD - 1)) begin
      n_bad++;
      $display("FAIL wait_tick: model state %0d pc %0d, required RUN pc %0d", m_st, m_pc, TD - 1);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (tick !== e.tick || running !== e.running || ten !== e.ten || one !== e.one ||
            sp !== e.sp || alarm_flag !== e.flag || state_o !== e.st) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got tick=%b run=%b cnt=%0d%0d sp=%b flag=%b st=%0d, required tick=%b run=%b cnt=%0d%0d sp=%b flag=%b st=%0d",
                   cyc_no, tick, running, ten, one, sp, alarm_flag, state_o,
                   e.tick, e.running, e.ten, e.one, e.sp, e.flag, e.st);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    idle_inputs();
    dir = 1'b0; load_val = 8'h00; alarm_val = 8'h99;
    rst = 1'b1;
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;

    // Count up 07..12 into ALARM, let the buzzer pattern run out, then ack the sticky flag.
    load_val = 8'h07; load = 1'b1; cycle(); load = 1'b0;
    alarm_val = 8'h12; start = 1'b1; cycle(); start = 1'b0;
    run(24);
    run(ALARM_LEN + 4);
    ack = 1'b1; cycle(); ack = 1'b0;
    run(2);

    // Count down through the 00 -> 99 borrow into ALARM at 98, ack mid-beep.
    dir = 1'b1; load_val = 8'h01; load = 1'b1; cycle(); load = 1'b0;
    alarm_val = 8'h98; start = 1'b1; cycle(); start = 1'b0;
    run_until_state(3);
    run(11);
    ack = 1'b1; cycle(); ack = 1'b0;
    run(3);

    // Up wrap 99 -> 00, stop exactly on a tick, resume from held prescaler.
    dir = 1'b0; load_val = 8'h98; load = 1'b1; cycle(); load = 1'b0;
    alarm_val = 8'h50; start = 1'b1; cycle(); start = 1'b0;
    run(8);
    run_until_tick();
    stop = 1'b1; cycle(); stop = 1'b0;
    run(2);
    start = 1'b1; cycle(); start = 1'b0;
    run(3);

    // Loads in PAUSE (invalid then valid), load ignored in RUN.
    stop = 1'b1; cycle(); stop = 1'b0;
    load_val = 8'h3A; load = 1'b1; cycle();
    load_val = 8'h45; cycle(); load = 1'b0;
    run(1);
    start = 1'b1; cycle(); start = 1'b0;
    load_val = 8'h22; load = 1'b1; run(6); load = 1'b0;

    // Reset mid-RUN and mid-ALARM; start+load together keeps the old count.
    rst = 1'b1; cycle(); rst = 1'b0;
    run(2);
    alarm_val = 8'h02; start = 1'b1; cycle(); start = 1'b0;
    run_until_state(3);
    run(5);
    rst = 1'b1; cycle(); rst = 1'b0;
    run(2);
    load_val = 8'h33; load = 1'b1; start = 1'b1; cycle();
    load = 1'b0; start = 1'b0;
    run(3);

    // Randomised traffic, steering alarm_val toward the next count now and then.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      ack   = ($urandom_range(0, 29) == 0);
      load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
      load_val = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      if ($urandom_range(0, 19) == 0)
        alarm_val = to_bcd(dir ? (m_cnt + 99) % 100 : (m_cnt + 1) % 100);
      else if ($urandom_range(0, 49) == 0)
        alarm_val = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      cycle();
    end

    idle_inputs();
    run(2);
    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
